// File: rtl/c17_pipe_pkg.sv
// c17_pipe_pkg: shared widths, net bit positions, MISR constants
// and BIST state encoding for the pipelined c17 array.
package c17_pipe_pkg;

  localparam int IN_W  = 5;
  localparam int OUT_W = 3;

  localparam int N1_B = 0;
  localparam int N2_B = 1;
  localparam int N3_B = 2;
  localparam int N6_B = 3;
  localparam int N7_B = 4;

  localparam int N22_B = 0;
  localparam int N23_B = 1;
  localparam int N20_B = 2;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    B_IDLE,
    B_FLUSH,
    B_RUN,
    B_DRAIN,
    B_DONE
  } bist_st_e;

  function automatic logic [15:0] misr_step(
    input logic [15:0]      s,
    input logic [OUT_W-1:0] f
  );
    return {s[14:0], 1'b0}
         ^ (s[15] ? MISR_POLY : 16'h0000)
         ^ {13'b0, f};
  endfunction

endpackage

// File: rtl/c17_pipe_array_ch.sv
// c17_lvl_ch: one channel of c17 plus parity, one register
// stage per logic level, all stages gated by a common enable.
module c17_lvl_ch
  import c17_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  logic n10_d, n11_d, n16_d, n19_d;
  logic n22_d, n23_d, par_d, n20_d;

  logic s1_n10_q, s1_n11_q, s1_n2_q, s1_n7_q;
  logic s2_n10_q, s2_n11_q, s2_n16_q, s2_n19_q;
  logic s3_n22_q, s3_n23_q, s3_par_q;
  logic s4_n20_q, s4_n22_q, s4_n23_q;

  assign n10_d = ~(in_i[N1_B] & in_i[N3_B]);
  assign n11_d = ~(in_i[N3_B] & in_i[N6_B]);
  assign n16_d = ~(s1_n2_q & s1_n11_q);
  assign n19_d = ~(s1_n11_q & s1_n7_q);
  assign n22_d = ~(s2_n10_q & s2_n16_q);
  assign n23_d = ~(s2_n16_q & s2_n19_q);
  // parity of the L1/L2 nets is folded early so S3 carries one bit
  assign par_d = s2_n10_q ^ s2_n11_q
               ^ s2_n16_q ^ s2_n19_q;
  assign n20_d = s3_par_q ^ s3_n23_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_n10_q <= 1'b0;
      s1_n11_q <= 1'b0;
      s1_n2_q  <= 1'b0;
      s1_n7_q  <= 1'b0;
      s2_n10_q <= 1'b0;
      s2_n11_q <= 1'b0;
      s2_n16_q <= 1'b0;
      s2_n19_q <= 1'b0;
      s3_n22_q <= 1'b0;
      s3_n23_q <= 1'b0;
      s3_par_q <= 1'b0;
      s4_n20_q <= 1'b0;
      s4_n22_q <= 1'b0;
      s4_n23_q <= 1'b0;
    end else if (en_i) begin
      s1_n10_q <= n10_d;
      s1_n11_q <= n11_d;
      s1_n2_q  <= in_i[N2_B];
      s1_n7_q  <= in_i[N7_B];
      s2_n10_q <= s1_n10_q;
      s2_n11_q <= s1_n11_q;
      s2_n16_q <= n16_d;
      s2_n19_q <= n19_d;
      s3_n22_q <= n22_d;
      s3_n23_q <= n23_d;
      s3_par_q <= par_d;
      s4_n20_q <= n20_d;
      s4_n22_q <= s3_n22_q;
      s4_n23_q <= s3_n23_q;
    end
  end

  always_comb begin
    out_o        = '0;
    out_o[N20_B] = s4_n20_q;
    out_o[N22_B] = s4_n22_q;
    out_o[N23_B] = s4_n23_q;
  end

endmodule

// File: rtl/c17_pipe_array.sv
// c17_pipe_array: NCH-channel 4-stage c17 pipeline with valid/ready
// and transfer counter. Define C17_PIPE_BIST_EN for exhaustive self-test.
module c17_pipe_array
  import c17_pipe_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W*NCH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W*NCH-1:0] out_data,
  output logic [CNT_W-1:0]     out_cnt
`ifdef C17_PIPE_BIST_EN
  ,
  input  logic                 bist_start,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic [15:0]          bist_sig
`endif
);

  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d;
  logic advance;
  logic [CNT_W-1:0] cnt_q;

  logic [IN_W-1:0]  ch_in  [NCH];
  logic [OUT_W-1:0] ch_out [NCH];

`ifdef C17_PIPE_BIST_EN
  bist_st_e st_q;
  logic [4:0]  c_q;
  logic [15:0] sig_q;
  logic [OUT_W-1:0] fold;
  logic bist_run, bist_act, bist_blk;
  logic pipe_empty, last_out;

  assign bist_run = (st_q == B_RUN);
  assign bist_act = bist_run | (st_q == B_DRAIN);
  assign bist_blk = bist_act | (st_q == B_FLUSH);
  assign pipe_empty = ~(v1_q | v2_q | v3_q | v4_q);
  assign last_out = v4_q & ~(v1_q | v2_q | v3_q);

  // self-test owns the pipe: it never stalls and hides its results
  assign advance   = bist_act | ~v4_q | out_ready;
  assign in_ready  = advance & ~bist_blk;
  assign out_valid = v4_q & ~bist_act;
  assign v1_d      = bist_run | (in_valid & in_ready);

  always_comb begin
    fold = '0;
    for (int k = 0; k < NCH; k++) fold ^= ch_out[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= B_IDLE;
      c_q   <= '0;
      sig_q <= '0;
    end else begin
      case (st_q)
        B_IDLE:
          if (bist_start) st_q <= B_FLUSH;
        B_FLUSH:
          if (pipe_empty) begin
            st_q  <= B_RUN;
            c_q   <= '0;
            sig_q <= MISR_SEED;
          end
        B_RUN: begin
          c_q <= c_q + 5'd1;
          if (v4_q) sig_q <= misr_step(sig_q, fold);
          if (&c_q) st_q <= B_DRAIN;
        end
        B_DRAIN: begin
          if (v4_q) sig_q <= misr_step(sig_q, fold);
          if (last_out) st_q <= B_DONE;
        end
        B_DONE:
          st_q <= bist_start ? B_FLUSH : B_IDLE;
        default:
          st_q <= B_IDLE;
      endcase
    end
  end

  assign bist_busy = bist_blk;
  assign bist_done = (st_q == B_DONE);
  assign bist_sig  = sig_q;
`else
  assign advance   = ~v4_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = v4_q;
  assign v1_d      = in_valid & in_ready;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
`ifdef C17_PIPE_BIST_EN
    assign ch_in[k] = bist_run
                    ? (c_q ^ 5'(k))
                    : in_data[IN_W*k +: IN_W];
`else
    assign ch_in[k] = in_data[IN_W*k +: IN_W];
`endif

    c17_lvl_ch u_ch (
      .clk   (clk),
      .rst   (rst),
      .en_i  (advance),
      .in_i  (ch_in[k]),
      .out_o (ch_out[k])
    );

    assign out_data[OUT_W*k +: OUT_W] = ch_out[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else if (advance) begin
      v1_q <= v1_d;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid & out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_cnt = cnt_q;

endmodule

// File: tb/tb_c17_pipe_array.sv
// tb_c17_pipe_array: random and directed stimulus against a
// queue-based c17 reference; second instance exercises CNT_W=4.
module tb_c17_pipe_array;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, out_ready;
  logic [19:0] in_data;
  logic        in_ready, out_valid;
  logic [11:0] out_data;
  logic [15:0] out_cnt;
  logic        in_ready4, out_valid4;
  logic [11:0] out_data4;
  logic [3:0]  out_cnt4;
`ifdef C17_PIPE_BIST_EN
  logic        bist_start;
  logic        bist_busy, bist_done;
  logic [15:0] bist_sig;
  logic        bist_busy4, bist_done4;
  logic [15:0] bist_sig4;
`endif

  c17_pipe_array #(.NCH(NCH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt)
`ifdef C17_PIPE_BIST_EN
    , .bist_start(bist_start), .bist_busy(bist_busy)
    , .bist_done(bist_done), .bist_sig(bist_sig)
`endif
  );

  c17_pipe_array #(.NCH(NCH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_cnt(out_cnt4)
`ifdef C17_PIPE_BIST_EN
    , .bist_start(bist_start), .bist_busy(bist_busy4)
    , .bist_done(bist_done4), .bist_sig(bist_sig4)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19, n22, n23, n20;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    n20 = n10 ^ n11 ^ n16 ^ n19 ^ n23;
    return {n20, n23, n22};
  endfunction

  function automatic logic [11:0] exp_word(input logic [19:0] d);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[3*k +: 3] = c17(d[5*k +: 5]);
    return r;
  endfunction

  function automatic logic [15:0] golden_sig();
    logic [15:0] s;
    logic [2:0]  f;
    s = 16'hFFFF;
    for (int c = 0; c < 32; c++) begin
      f = '0;
      for (int k = 0; k < NCH; k++) f ^= c17(5'(c ^ k));
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {13'b0, f};
    end
    return s;
  endfunction

  logic [11:0] exp_q[$];
  int          cnt_m = 0;
  bit          last_ov = 0;
  logic [11:0] last_out;
  bit          prev_stall = 0;
  logic [11:0] prev_data;

  task automatic tick();
    logic [11:0] e;
    #1;
    last_ov = out_valid;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    chk("cnt", out_cnt, cnt_m & 16'hFFFF);
    chk("cnt4", out_cnt4, cnt_m & 4'hF);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        last_out = out_data;
        chk("data", out_data, e);
        chk("valid4", out_valid4, 1);
        chk("data4", out_data4, e);
      end
      cnt_m++;
    end
    if (in_valid && in_ready) begin
      chk("rdy4", in_ready4, 1);
      exp_q.push_back(exp_word(in_data));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(negedge clk);
  endtask

  task automatic send_one(input logic [19:0] d,
                          input logic [11:0] expc,
                          input string tag);
    int lat;
    last_out = 'x;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (last_ov) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_out"}, last_out, expc);
  endtask

  task automatic stream(input int n, output int best);
    int r;
    best = 0;
    r = 0;
    for (int i = 0; i < n + 10; i++) begin
      in_valid = (i < n);
      in_data  = 20'($urandom);
      tick();
      r = last_ov ? r + 1 : 0;
      if (r > best) best = r;
    end
    in_valid = 1'b0;
  endtask

`ifdef C17_PIPE_BIST_EN
  task automatic run_bist(input string tag, output logic [15:0] sig);
    bit busy, done;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 20'($urandom);
      tick();
    end
    in_valid   = 1'b0;
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    busy = 0;
    done = 0;
    for (int n = 0; n < 300; n++) begin
      busy |= bist_busy;
      chk({tag, "_busy4"}, bist_busy4, bist_busy);
      tick();
      if (bist_done) begin
        done = 1;
        break;
      end
    end
    sig = bist_sig;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sig"}, bist_sig, golden_sig());
    chk({tag, "_sig4"}, bist_sig4, golden_sig());
    chk({tag, "_done4"}, bist_done4, 1);
    tick();
    chk({tag, "_idle"}, bist_done, 0);
    chk({tag, "_held"}, bist_sig, golden_sig());
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int best;
`ifdef C17_PIPE_BIST_EN
    logic [15:0] s1, s2;
    bist_start = 1'b0;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    send_one(20'h00000, 12'h000, "zeros");
    send_one(20'hFFFFF, 12'h249, "ones");
    send_one(20'h00013, 12'h007, "ch0_13");

    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 20'($urandom);
      tick();
    end
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_fill", exp_q.size(), 4);
    for (int i = 0; i < 3; i++) tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    best = cnt_m;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_drain", cnt_m - best, 4);
    chk("stall_empty", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 20'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_cnt", out_cnt, 0);
    chk("arst_out_cnt4", out_cnt4, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    prev_stall = 0;
    send_one(20'hFFFFF, 12'h249, "post_rst");

    stream(16, best);
    chk("cnt4_wrap", out_cnt4, 1);
    stream(32, best);
    chk("run32", best, 32);
    chk("cnt49", out_cnt, 49);

    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_data   = 20'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rand_empty", exp_q.size(), 0);

`ifdef C17_PIPE_BIST_EN
    run_bist("bist1", s1);
    run_bist("bist2", s2);
    chk("bist_repeat", s2, s1);
    send_one(20'h00013, 12'h007, "post_bist");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
